// File: rtl/match_controller_pkg.sv
// Shared game definitions: sequencer state encoding, round/winner codes and
// the health ceiling used by both this block and health tracking.
package match_controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INTRO      = 3'd1,
    S_FIGHT      = 3'd2,
    S_ROUND_END  = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_P1   = 2'd1;
  localparam logic [1:0] RES_P2   = 2'd2;
  localparam logic [1:0] RES_DRAW = 2'd3;

  localparam int MAX_HEALTH = 3;

  // Health tracking wraps below zero to large values; treat those as empty.
  function automatic logic [2:0] h_eff(input logic [2:0] health);
    return (health > 3'(MAX_HEALTH)) ? 3'd0 : health;
  endfunction

endpackage

// File: rtl/match_controller_tick_down_counter.sv
// Loadable down-counter that steps on an enable and sticks at zero.
module tick_down_counter #(
  parameter int          W         = 8,
  parameter logic [W-1:0] RST_VALUE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: intro countdown, fight timer, KO/time-out judging,
// win tally and match winner. All outputs are registered from next-state.
module match_controller
  import match_controller_pkg::*;
#(
  parameter int ROUNDS_TO_WIN = 2,
  parameter int ROUND_TIME    = 60,
  parameter int INTRO_TICKS   = 3,
  parameter int END_TICKS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sec_tick,
  input  logic [2:0] player1_health,
  input  logic [2:0] player2_health,
  output logic       round_rst,
  output logic       fight_enable,
  output logic [6:0] round_timer,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [1:0] round_result,
  output logic       match_over,
  output logic [1:0] match_winner,
  output state_t     state_dbg
);

  localparam logic [1:0] WIN_TARGET = 2'(ROUNDS_TO_WIN);
  localparam logic [6:0] TIME_INIT  = 7'(ROUND_TIME);
  localparam logic [7:0] INTRO_INIT = 8'(INTRO_TICKS);
  localparam logic [7:0] END_INIT   = 8'(END_TICKS);

  state_t     state, next_state;
  logic       timer_zero, timer_load, timer_dec;
  logic [7:0] phase, phase_init;
  logic       phase_zero, phase_load, phase_en, phase_done;
  logic       fight_armed, entering;
  logic [2:0] p1_h, p2_h;
  logic       p1_ko, p2_ko, ko_any;
  logic [2:0] round_num_n;
  logic [1:0] p1_wins_n, p2_wins_n, result_n;

  always_comb begin
    p1_h        = h_eff(player1_health);
    p2_h        = h_eff(player2_health);
    p1_ko       = (p1_h == 3'd0);
    p2_ko       = (p2_h == 3'd0);
    // fight_armed is low on the first FIGHT cycle while health is reloading.
    ko_any      = fight_armed && (p1_ko || p2_ko);
    phase_done  = phase_zero || (sec_tick && (phase == 8'd1));
    next_state  = state;
    round_num_n = round_num;
    p1_wins_n   = p1_wins;
    p2_wins_n   = p2_wins;
    result_n    = round_result;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state  = S_INTRO;
          round_num_n = 3'd1;
          p1_wins_n   = 2'd0;
          p2_wins_n   = 2'd0;
          result_n    = RES_NONE;
        end
      end
      S_INTRO: begin
        if (phase_done) next_state = S_FIGHT;
      end
      S_FIGHT: begin
        if (ko_any || timer_zero) begin
          next_state = S_ROUND_END;
          if (ko_any) begin
            if (p1_ko && p2_ko) result_n = RES_DRAW;
            else if (p2_ko)     result_n = RES_P1;
            else                result_n = RES_P2;
          end else begin
            if (p1_h > p2_h)      result_n = RES_P1;
            else if (p2_h > p1_h) result_n = RES_P2;
            else                  result_n = RES_DRAW;
          end
          if ((result_n == RES_P1) && (p1_wins < WIN_TARGET)) p1_wins_n = p1_wins + 2'd1;
          if ((result_n == RES_P2) && (p2_wins < WIN_TARGET)) p2_wins_n = p2_wins + 2'd1;
        end
      end
      S_ROUND_END: begin
        if (phase_done) begin
          if ((p1_wins == WIN_TARGET) || (p2_wins == WIN_TARGET)) begin
            next_state = S_MATCH_OVER;
          end else begin
            next_state = S_INTRO;
            if (round_num != 3'd7) round_num_n = round_num + 3'd1;
          end
        end
      end
      S_MATCH_OVER: begin
        if (start) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A tick coinciding with the KO that ends a round already counts toward
  // the result display; the tick that ends a phase belongs to that phase.
  always_comb begin
    entering   = (next_state != state);
    timer_load = (next_state == S_IDLE) || (entering && (next_state == S_INTRO));
    timer_dec  = sec_tick && (state == S_FIGHT) && (next_state == S_FIGHT);
    phase_load = entering && ((next_state == S_INTRO) || (next_state == S_ROUND_END));
    phase_en   = sec_tick && ((state == S_INTRO) || (state == S_ROUND_END));
    phase_init = INTRO_INIT;
    if (next_state == S_ROUND_END) begin
      phase_init = (sec_tick && (END_INIT != 8'd0)) ? END_INIT - 8'd1 : END_INIT;
    end
  end

  tick_down_counter #(.W(7), .RST_VALUE(TIME_INIT)) u_round_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_value (TIME_INIT),
    .en         (timer_dec),
    .count      (round_timer),
    .zero       (timer_zero)
  );

  tick_down_counter #(.W(8), .RST_VALUE(8'd0)) u_phase_count (
    .clk        (clk),
    .rst        (rst),
    .load       (phase_load),
    .load_value (phase_init),
    .en         (phase_en),
    .count      (phase),
    .zero       (phase_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      round_num    <= 3'd1;
      p1_wins      <= 2'd0;
      p2_wins      <= 2'd0;
      round_result <= RES_NONE;
      round_rst    <= 1'b1;
      fight_enable <= 1'b0;
      fight_armed  <= 1'b0;
      match_over   <= 1'b0;
      match_winner <= RES_NONE;
    end else begin
      state        <= next_state;
      round_num    <= round_num_n;
      p1_wins      <= p1_wins_n;
      p2_wins      <= p2_wins_n;
      round_result <= result_n;
      round_rst    <= (next_state == S_IDLE) || (entering && (next_state == S_INTRO));
      fight_enable <= (next_state == S_FIGHT);
      fight_armed  <= (state == S_FIGHT) && (next_state == S_FIGHT);
      match_over   <= (next_state == S_MATCH_OVER);
      if (next_state == S_MATCH_OVER)
        match_winner <= (p1_wins_n == WIN_TARGET) ? RES_P1 : RES_P2;
      else
        match_winner <= RES_NONE;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with default parameters; inputs are
// driven and outputs sampled 1ns after each rising edge.
module tb_match_controller;
  import match_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, sec_tick;
  logic [2:0] player1_health, player2_health;
  logic       round_rst, fight_enable, match_over;
  logic [6:0] round_timer;
  logic [2:0] round_num;
  logic [1:0] p1_wins, p2_wins, round_result, match_winner;
  state_t     state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  match_controller dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sec_tick       (sec_tick),
    .player1_health (player1_health),
    .player2_health (player2_health),
    .round_rst      (round_rst),
    .fight_enable   (fight_enable),
    .round_timer    (round_timer),
    .round_num      (round_num),
    .p1_wins        (p1_wins),
    .p2_wins        (p2_wins),
    .round_result   (round_result),
    .match_over     (match_over),
    .match_winner   (match_winner),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Intro countdown, one idle FIGHT cycle, then P2 health wraps to 7.
  task automatic p1_underflow_round(input string tag, input logic [7:0] exp_p1);
    ticks(3);
    check({tag, "_fight"}, 8'(state_dbg), 8'(S_FIGHT));
    step();
    player2_health = 3'd7;
    step();
    check({tag, "_end"}, 8'(state_dbg), 8'(S_ROUND_END));
    check({tag, "_res"}, 8'(round_result), 8'(RES_P1));
    check({tag, "_p1w"}, 8'(p1_wins), exp_p1);
    player2_health = 3'd3;
    ticks(2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sec_tick = 1'b0;
    player1_health = 3'd3; player2_health = 3'd3;
    step(); step();
    rst = 1'b0;
    check("rst_state", 8'(state_dbg), 8'(S_IDLE));
    check("rst_round_rst", 8'(round_rst), 8'd1);
    check("rst_fight_en", 8'(fight_enable), 8'd0);
    check("rst_timer", 8'(round_timer), 8'd60);
    check("rst_round_num", 8'(round_num), 8'd1);
    check("rst_wins", {4'd0, p1_wins, p2_wins}, 8'd0);
    check("rst_result", 8'(round_result), 8'd0);
    check("rst_match", {5'd0, match_over, match_winner}, 8'd0);
    step();
    check("idle_round_rst", 8'(round_rst), 8'd1);

    // Match 1, round 1: KO of P2
    pulse_start();
    check("intro_state", 8'(state_dbg), 8'(S_INTRO));
    check("intro_rst_first", 8'(round_rst), 8'd1);
    check("intro_timer", 8'(round_timer), 8'd60);
    step();
    check("intro_rst_low", 8'(round_rst), 8'd0);
    ticks(2);
    check("pre_fight_en", 8'(fight_enable), 8'd0);
    tick();
    check("fight_en_rise", 8'(fight_enable), 8'd1);
    check("fight_timer", 8'(round_timer), 8'd60);
    step();
    player2_health = 3'd2;
    step();
    player2_health = 3'd0;
    step();
    check("ko_state", 8'(state_dbg), 8'(S_ROUND_END));
    check("ko_result", 8'(round_result), 8'(RES_P1));
    check("ko_p1w", 8'(p1_wins), 8'd1);
    check("ko_fight_en", 8'(fight_enable), 8'd0);
    player2_health = 3'd3;
    tick();
    check("end_hold", 8'(state_dbg), 8'(S_ROUND_END));
    tick();
    check("r2_state", 8'(state_dbg), 8'(S_INTRO));
    check("r2_num", 8'(round_num), 8'd2);
    check("r2_round_rst", 8'(round_rst), 8'd1);

    // Round 2: double KO at FIGHT entry; first cycle ignores it
    ticks(2);
    player1_health = 3'd0; player2_health = 3'd0;
    tick();
    check("dko_enter", 8'(state_dbg), 8'(S_FIGHT));
    step();
    check("dko_suppress", 8'(state_dbg), 8'(S_FIGHT));
    tick();
    check("dko_state", 8'(state_dbg), 8'(S_ROUND_END));
    check("dko_result", 8'(round_result), 8'(RES_DRAW));
    check("dko_wins", {4'd0, p1_wins, p2_wins}, 8'b0000_0100);
    check("dko_timer", 8'(round_timer), 8'd60);
    player1_health = 3'd2; player2_health = 3'd2;
    tick();
    check("r3_state", 8'(state_dbg), 8'(S_INTRO));
    check("r3_num", 8'(round_num), 8'd3);

    // Round 3: time-out with equal health
    ticks(3);
    ticks(60);
    check("tie_timer0", 8'(round_timer), 8'd0);
    step();
    check("tie_result", 8'(round_result), 8'(RES_DRAW));
    check("tie_wins", {4'd0, p1_wins, p2_wins}, 8'b0000_0100);
    ticks(2);
    check("r4_num", 8'(round_num), 8'd4);

    // Round 4: time-out, P1 ahead on health, takes the match
    player1_health = 3'd2; player2_health = 3'd1;
    ticks(3);
    ticks(59);
    check("to_timer1", 8'(round_timer), 8'd1);
    tick();
    check("to_timer0", 8'(round_timer), 8'd0);
    check("to_fight_en_hi", 8'(fight_enable), 8'd1);
    step();
    check("to_fight_en_lo", 8'(fight_enable), 8'd0);
    check("to_result", 8'(round_result), 8'(RES_P1));
    check("to_p1w", 8'(p1_wins), 8'd2);
    ticks(2);
    check("m1_over", 8'(match_over), 8'd1);
    check("m1_winner", 8'(match_winner), 8'(RES_P1));
    tick();
    check("m1_tick_ignored", 8'(state_dbg), 8'(S_MATCH_OVER));
    start = 1'b1;
    step();
    check("m1_idle", 8'(state_dbg), 8'(S_IDLE));
    check("m1_idle_over", 8'(match_over), 8'd0);
    step();
    start = 1'b0;
    check("m2_intro", 8'(state_dbg), 8'(S_INTRO));
    check("m2_wins_clr", {4'd0, p1_wins, p2_wins}, 8'd0);
    check("m2_num", 8'(round_num), 8'd1);
    player1_health = 3'd3; player2_health = 3'd3;

    // Match 2: underflow KO, then reset mid-FIGHT
    p1_underflow_round("m2r1", 8'd1);
    ticks(3);
    ticks(20);
    check("mid_timer", 8'(round_timer), 8'd40);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", 8'(state_dbg), 8'(S_IDLE));
    check("mid_rst_timer", 8'(round_timer), 8'd60);
    check("mid_rst_wins", {4'd0, p1_wins, p2_wins}, 8'd0);
    check("mid_rst_fight_en", 8'(fight_enable), 8'd0);
    check("mid_rst_round_rst", 8'(round_rst), 8'd1);
    check("mid_rst_num", 8'(round_num), 8'd1);

    // Match 3: two underflow KOs for P1
    pulse_start();
    p1_underflow_round("m3r1", 8'd1);
    check("m3r2_num", 8'(round_num), 8'd2);
    p1_underflow_round("m3r2", 8'd2);
    check("m3_over", 8'(match_over), 8'd1);
    check("m3_winner", 8'(match_winner), 8'(RES_P1));
    pulse_start();
    check("m3_idle", 8'(state_dbg), 8'(S_IDLE));
    check("m3_idle_winner", 8'(match_winner), 8'd0);
    pulse_start();
    check("m4_wins_clr", {4'd0, p1_wins, p2_wins}, 8'd0);
    check("m4_result_clr", 8'(round_result), 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
